// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/decode control inputs, instruction memory
// port and the IF/ID register outputs presented to decode.
interface if_stage_if;
    logic        stall;
    logic [2:0]  Br;
    logic        b_jump;
    logic [15:0] imm16_D;
    logic [25:0] imm26_D;
    logic [31:0] rs_val_D;
    logic [31:0] i_rdata;
    logic [31:0] i_addr;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] link_D;

    // Surrounding pipeline / instruction memory side
    modport master (
        output stall, Br, b_jump, imm16_D, imm26_D, rs_val_D, i_rdata,
        input  i_addr, instr_D, pc_D, link_D
    );

    // Fetch stage side
    modport slave (
        input  stall, Br, b_jump, imm16_D, imm26_D, rs_val_D, i_rdata,
        output i_addr, instr_D, pc_D, link_D
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC_F register, next-PC selection and the
// IF/ID pipeline register. One architectural delay slot, no flush.
module if_stage (
    input  logic         clk,
    input  logic         reset,
    if_stage_if.slave    bus
);
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic [31:0] pc_f_q,    pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q,    pc_d_d;

    logic [31:0] pc4_f;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;

    assign pc4_f     = pc_f_q + 32'd4;
    // Branch target is relative to the delay-slot address, i.e. pc_D + 4.
    assign br_target = pc_d_q + 32'd4 + {{14{bus.imm16_D[15]}}, bus.imm16_D, 2'b00};
    assign j_target  = {pc_d_q[31:28], bus.imm26_D, 2'b00};

    // Next-PC select; encodings 4-7 fall back to sequential fetch.
    always_comb begin
        npc = pc4_f;
        case (bus.Br)
            3'd1:    npc = bus.b_jump ? br_target : pc4_f;
            3'd2:    npc = j_target;
            3'd3:    npc = bus.rs_val_D;
            default: npc = pc4_f;
        endcase
    end

    // Advance or freeze the fetch PC and IF/ID register.
    always_comb begin
        pc_f_d    = pc_f_q;
        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        if (!bus.stall) begin
            pc_f_d    = npc;
            instr_d_d = bus.i_rdata;
            pc_d_d    = pc_f_q;
        end
    end

    // State register with synchronous reset overriding stall and redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q    <= RESET_PC;
            instr_d_q <= 32'h0000_0000;
            pc_d_q    <= 32'h0000_0000;
        end else begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_d_d;
        end
    end

    assign bus.i_addr  = pc_f_q;
    assign bus.instr_D = instr_d_q;
    assign bus.pc_D    = pc_d_q;
    assign bus.link_D  = pc_d_q + 32'd8;
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, a couple of
// hand-written reset sequences and randomized traffic against a model.
`timescale 1ns/1ps
module tb_if_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    if_stage_if bus();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign bus.i_rdata = imem(bus.i_addr);

    // Reference model state
    logic [31:0] m_pcf, m_instr, m_pcd;

    function automatic logic [31:0] model_npc(input logic [2:0] br, input logic bj,
                                              input logic [15:0] i16, input logic [25:0] i26,
                                              input logic [31:0] rs);
        longint off;
        logic [31:0] r;
        off = longint'($signed(i16)) * 4;
        case (br)
            3'd1: r = bj ? 32'(longint'(m_pcd) + 4 + off) : 32'(longint'(m_pcf) + 4);
            3'd2: r = (m_pcd & 32'hF000_0000) | (32'(i26) * 4);
            3'd3: r = rs;
            default: r = 32'(longint'(m_pcf) + 4);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic [2:0] br, input logic bj,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        reset        = rst;
        bus.stall    = st;
        bus.Br       = br;
        bus.b_jump   = bj;
        bus.imm16_D  = i16;
        bus.imm26_D  = i26;
        bus.rs_val_D = rs;
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic step_model(input string tag, input logic rst, input logic st, input logic [2:0] br,
                              input logic bj, input logic [15:0] i16, input logic [25:0] i26,
                              input logic [31:0] rs);
        logic [31:0] n;
        drive(rst, st, br, bj, i16, i26, rs);
        n = model_npc(br, bj, i16, i26, rs);
        @(posedge clk);
        if (rst) begin
            m_pcf = 32'h3000; m_instr = 32'h0; m_pcd = 32'h0;
        end else if (!st) begin
            m_instr = imem(m_pcf); m_pcd = m_pcf; m_pcf = n;
        end
        #1;
        check({tag, ".i_addr"},  bus.i_addr,  m_pcf);
        check({tag, ".instr_D"}, bus.instr_D, m_instr);
        check({tag, ".pc_D"},    bus.pc_D,    m_pcd);
        check({tag, ".link_D"},  bus.link_D,  m_pcd + 32'd8);
    endtask

    typedef struct {
        logic        rst;
        logic        st;
        logic [2:0]  br;
        logic        bj;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs;
        logic [31:0] exp_iaddr;
        logic [31:0] exp_pcd;
        logic        exp_nop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic [2:0] br, input logic bj,
                                input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                                input logic [31:0] ei, input logic [31:0] ep, input logic en);
        vec_t v;
        v.rst = rst; v.st = st; v.br = br; v.bj = bj; v.i16 = i16; v.i26 = i26; v.rs = rs;
        v.exp_iaddr = ei; v.exp_pcd = ep; v.exp_nop = en;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);

        //                rst st  br   bj  imm16    imm26      rs            i_addr        pc_D          nop
        vecs.push_back(mk(1, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3000, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3004, 32'h0000_3000, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3008, 32'h0000_3004, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 16'hFFFE, 26'h0,     32'h0,        32'h0000_3000, 32'h0000_3008, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3004, 32'h0000_3000, 0));
        vecs.push_back(mk(0, 0, 3'd1, 0, 16'hFFFE, 26'h0,     32'h0,        32'h0000_3008, 32'h0000_3004, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_300C, 32'h0000_3008, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3010, 32'h0000_300C, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_3014, 32'h0000_3010, 0));
        vecs.push_back(mk(0, 0, 3'd2, 0, 16'h0000, 26'h0C40,  32'h0,        32'h0000_3100, 32'h0000_3014, 0));
        vecs.push_back(mk(0, 0, 3'd3, 0, 16'h0000, 26'h0,     32'h0000_3200, 32'h0000_3200, 32'h0000_3100, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 16'h0004, 26'h0,     32'h0,        32'h0000_3200, 32'h0000_3100, 0));
        vecs.push_back(mk(0, 1, 3'd1, 1, 16'h0004, 26'h0,     32'h0,        32'h0000_3200, 32'h0000_3100, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 16'h0004, 26'h0,     32'h0,        32'h0000_3114, 32'h0000_3200, 0));
        vecs.push_back(mk(1, 1, 3'd3, 0, 16'h0000, 26'h0,     32'h0000_5555, 32'h0000_3000, 32'h0000_0000, 1));
        vecs.push_back(mk(0, 0, 3'd3, 0, 16'h0000, 26'h0,     32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3000, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_0000, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 3'd1, 1, 16'h0001, 26'h0,     32'h0,        32'h0000_0004, 32'h0000_0000, 0));
        vecs.push_back(mk(0, 0, 3'd5, 1, 16'h0040, 26'h3FF,   32'h0,        32'h0000_0008, 32'h0000_0004, 0));
        vecs.push_back(mk(0, 0, 3'd3, 0, 16'h0000, 26'h0,     32'h0000_1003, 32'h0000_1003, 32'h0000_0008, 0));
        vecs.push_back(mk(0, 0, 3'd0, 0, 16'h0000, 26'h0,     32'h0,        32'h0000_1007, 32'h0000_1003, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].bj, vecs[i].i16, vecs[i].i26, vecs[i].rs);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.i_addr", i), bus.i_addr, vecs[i].exp_iaddr);
            check($sformatf("vec%0d.pc_D", i),   bus.pc_D,   vecs[i].exp_pcd);
            check($sformatf("vec%0d.instr_D", i), bus.instr_D,
                  vecs[i].exp_nop ? 32'h0 : imem(vecs[i].exp_pcd));
            check($sformatf("vec%0d.link_D", i), bus.link_D, vecs[i].exp_pcd + 32'd8);
        end

        // Hand sequence: reset held for two edges under a pending jump,
        // then the first fetch must restart at 0x3000.
        m_pcf = bus.i_addr; m_instr = bus.instr_D; m_pcd = bus.pc_D;
        step_model("rst_hold0", 1, 0, 3'd2, 0, 16'h0, 26'h3FF_FFFF, 32'h0);
        step_model("rst_hold1", 1, 1, 3'd1, 1, 16'h8000, 26'h0, 32'h0);
        step_model("rst_rel",   0, 0, 3'd0, 0, 16'h0, 26'h0, 32'h0);
        check("rst_rel.first_pc_D", bus.pc_D, 32'h0000_3000);

        // Hand sequence: stall during a jr, released with a different target.
        step_model("stall_jr0", 0, 1, 3'd3, 0, 16'h0, 26'h0, 32'h0000_8000);
        step_model("stall_jr1", 0, 0, 3'd3, 0, 16'h0, 26'h0, 32'h0000_9000);
        check("stall_jr.target", bus.i_addr, 32'h0000_9000);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            rs = $urandom;
            if ($urandom_range(0, 3) == 0) rs = rs & 32'h0000_FFFC;
            step_model($sformatf("rnd%0d", i),
                       $urandom_range(0, 39) == 0,
                       $urandom_range(0, 3) == 0,
                       3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)),
                       16'($urandom),
                       26'($urandom),
                       rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
